// File: rtl/tx_frame_pkg.sv
// Shared state encoding, default widths and constants for the transmit framer.
// No timing of its own; no flow control.
package tx_frame_pkg;

  localparam int DEF_HDR_WIDTH     = 8;
  localparam int DEF_LEN_WIDTH     = 8;
  localparam int DEF_PAY_LEN_WIDTH = 16;
  localparam int MIN_TRN_LEN       = 2;

  typedef enum logic [2:0] {
    IDLE,
    TRN,
    MARK,
    GUARD,
    HDR,
    PAY
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tx_frame_gen_if.sv
// Framer control, payload handshake and bit-stream signals bundled together.
// slave = framer side; master = the block that requests frames and feeds payload.
interface tx_frame_gen_if
  import tx_frame_pkg::*;
#(
  parameter int HDR_WIDTH     = DEF_HDR_WIDTH,
  parameter int LEN_WIDTH     = DEF_LEN_WIDTH,
  parameter int PAY_LEN_WIDTH = DEF_PAY_LEN_WIDTH
) ();

  logic                     clk_enable;
  logic [LEN_WIDTH-1:0]     TX_TRN_LEN;
  logic [LEN_WIDTH-1:0]     TX_GUARD_LEN;
  logic [PAY_LEN_WIDTH-1:0] TX_PAY_LEN;
  logic                     start;
  logic [HDR_WIDTH-1:0]     hdr;
  logic                     pay_bit;
  logic                     pay_vld;
  logic                     pay_rdy;
  logic                     BPSK;
  logic                     tx_vld;
  logic                     busy;
  logic                     done;
  logic                     tx_sgn;
  logic                     underflow;

  modport slave (
    input  clk_enable, TX_TRN_LEN, TX_GUARD_LEN, TX_PAY_LEN, start, hdr, pay_bit, pay_vld,
    output pay_rdy, BPSK, tx_vld, busy, done, tx_sgn, underflow
  );

  modport master (
    output clk_enable, TX_TRN_LEN, TX_GUARD_LEN, TX_PAY_LEN, start, hdr, pay_bit, pay_vld,
    input  pay_rdy, BPSK, tx_vld, busy, done, tx_sgn, underflow
  );

endinterface

// File: rtl/tx_hdr_serializer.sv
// MSB-first parallel-to-serial shifter for the header; current bit and last-bit flag are
// combinational from the register. No backpressure: shifts whenever told to.
module tx_hdr_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] dat,
  output logic             ser_bit,
  output logic             last
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] sr;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      idx <= '0;
    end else if (load) begin
      sr  <= dat;
      idx <= '0;
    end else if (shift) begin
      sr  <= sr << 1;
      idx <= idx + 1'b1;
    end
  end

  assign ser_bit = sr[WIDTH-1];
  assign last    = (idx == IDX_W'(WIDTH - 1));

endmodule

// File: rtl/tx_frame_gen.sv
// BPSK framer: TRN alternation, sign marker, guard, header, payload; first bit registered on the
// enable edge that samples start. Payload is never waited for: a missing bit goes out as 0 and flags underflow.
module tx_frame_gen
  import tx_frame_pkg::*;
#(
  parameter int HDR_WIDTH     = DEF_HDR_WIDTH,
  parameter int LEN_WIDTH     = DEF_LEN_WIDTH,
  parameter int PAY_LEN_WIDTH = DEF_PAY_LEN_WIDTH
) (
  input logic          clk,
  input logic          rst,
  tx_frame_gen_if.slave bus
);

  localparam int CNT_W = max_int(LEN_WIDTH, PAY_LEN_WIDTH);

  // state names the phase of the bit produced at the next enable edge.
  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [LEN_WIDTH-1:0]     guard_len, guard_len_nxt;
  logic [PAY_LEN_WIDTH-1:0] pay_len, pay_len_nxt;
  logic                     ph, ph_nxt;
  logic                     bpsk, bpsk_nxt;
  logic                     vld, vld_nxt;
  logic                     done, done_nxt;
  logic                     sgn, sgn_nxt;
  logic                     unf, unf_nxt;
  logic                     ser_load, ser_shift, ser_bit, ser_last;
  logic [LEN_WIDTH-1:0]     trn_len;

  assign trn_len = (bus.TX_TRN_LEN < LEN_WIDTH'(MIN_TRN_LEN)) ? LEN_WIDTH'(MIN_TRN_LEN)
                                                               : bus.TX_TRN_LEN;

  tx_hdr_serializer #(.WIDTH(HDR_WIDTH)) u_hdr (
    .clk     (clk),
    .rst     (rst),
    .load    (ser_load),
    .shift   (ser_shift),
    .dat     (bus.hdr),
    .ser_bit (ser_bit),
    .last    (ser_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      guard_len <= '0;
      pay_len   <= '0;
      ph        <= 1'b0;
      bpsk      <= 1'b0;
      vld       <= 1'b0;
      done      <= 1'b0;
      sgn       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      guard_len <= guard_len_nxt;
      pay_len   <= pay_len_nxt;
      ph        <= ph_nxt;
      bpsk      <= bpsk_nxt;
      vld       <= vld_nxt;
      done      <= done_nxt;
      sgn       <= sgn_nxt;
      unf       <= unf_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    guard_len_nxt = guard_len;
    pay_len_nxt   = pay_len;
    ph_nxt        = ph;
    bpsk_nxt      = bpsk;
    vld_nxt       = vld;
    done_nxt      = done;
    sgn_nxt       = sgn;
    unf_nxt       = unf;
    ser_load      = 1'b0;
    ser_shift     = 1'b0;
    if (bus.clk_enable) begin
      done_nxt = 1'b0;
      unique case (state)
        IDLE: begin
          bpsk_nxt = 1'b0;
          vld_nxt  = 1'b0;
          // vld still high means the last frame bit is on the line: close the frame first.
          if (vld) begin
            done_nxt = 1'b1;
          end else if (bus.start) begin
            state_nxt     = TRN;
            cnt_nxt       = CNT_W'(trn_len) - CNT_W'(MIN_TRN_LEN);
            vld_nxt       = 1'b1;
            ph_nxt        = 1'b1;
            sgn_nxt       = 1'b0;
            unf_nxt       = 1'b0;
            guard_len_nxt = bus.TX_GUARD_LEN;
            pay_len_nxt   = bus.TX_PAY_LEN;
            ser_load      = 1'b1;
          end
        end
        TRN: begin
          bpsk_nxt = ph;
          ph_nxt   = ~ph;
          if (cnt == '0) state_nxt = MARK;
          else           cnt_nxt   = cnt - 1'b1;
        end
        MARK: begin
          bpsk_nxt = ~ph;
          sgn_nxt  = ~ph;
          if (guard_len == '0) begin
            state_nxt = HDR;
          end else begin
            state_nxt = GUARD;
            cnt_nxt   = CNT_W'(guard_len) - 1'b1;
          end
        end
        GUARD: begin
          bpsk_nxt = ph;
          ph_nxt   = ~ph;
          if (cnt == '0) state_nxt = HDR;
          else           cnt_nxt   = cnt - 1'b1;
        end
        HDR: begin
          bpsk_nxt  = ser_bit;
          ser_shift = 1'b1;
          if (ser_last) begin
            if (pay_len == '0) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = PAY;
              cnt_nxt   = CNT_W'(pay_len) - 1'b1;
            end
          end
        end
        PAY: begin
          bpsk_nxt = bus.pay_vld & bus.pay_bit;
          if (!bus.pay_vld) unf_nxt = 1'b1;
          if (cnt == '0) state_nxt = IDLE;
          else           cnt_nxt   = cnt - 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.pay_rdy   = bus.clk_enable & (state == PAY);
  assign bus.BPSK      = bpsk;
  assign bus.tx_vld    = vld;
  assign bus.busy      = vld;
  assign bus.done      = done;
  assign bus.tx_sgn    = sgn;
  assign bus.underflow = unf;

endmodule

// File: doc/tx_frame_gen.md
Name: tx_frame_gen

Overview:
- Transmit-side framer that produces the BPSK bit stream the receiver uses for packet sync.
- Emits a frame of TRN field (alternating bits), one sign-inversion marker (repeated bit), guard alternation, header, then payload.
- Sits ahead of the modulator. One bit per clk_enable cycle.
- The marker is the transition the receiver boundary detector locks on; the guard covers its confirmation window.

Parameters:
- HDR_WIDTH, 8, header length in bits, sent MSB first.
- LEN_WIDTH, 8, width of TX_TRN_LEN and TX_GUARD_LEN.
- PAY_LEN_WIDTH, 16, width of TX_PAY_LEN.

Ports:
- clk  in  1  system clock; one clock only.
- rst  in  1  reset; synchronous, active-high.
- clk_enable  in  1  symbol-rate enable; all state advances only when high.
- TX_TRN_LEN  in  LEN_WIDTH  TRN bit count; values <2 are treated as 2.
- TX_GUARD_LEN  in  LEN_WIDTH  post-marker alternating bits, 0 allowed; must be >= receiver window.
- TX_PAY_LEN  in  PAY_LEN_WIDTH  payload bit count, 0 allowed.
- start  in  1  frame request, sampled in IDLE on an enable cycle.
- hdr  in  HDR_WIDTH  header value, latched with start.
- pay_bit  in  1  payload bit.
- pay_vld  in  1  payload bit valid.
- pay_rdy  out  1  payload consume strobe (combinational).
- BPSK  out  1  registered output bit.
- tx_vld  out  1  BPSK is a frame bit.
- busy  out  1  frame in progress.
- done  out  1  one-enable-cycle pulse after the last frame bit.
- tx_sgn  out  1  value of the marker bit, held until the next start.
- underflow  out  1  sticky payload starvation flag, cleared on start.

Behaviour:
- Reset, or rst asserted mid-frame: state=IDLE; all counters 0; every output 0 on the next clk edge. The frame is abandoned with no done pulse.
- clk_enable low: all registers hold; pay_rdy=0.
- States:
  - IDLE -> TRN on start (enable cycle). Latch lengths and hdr; clear underflow. start while busy is ignored.
  - TRN: emit a phase bit p starting at 0 and toggling each symbol (0,1,0,1,...) for max(TX_TRN_LEN,2) bits. -> MARK.
  - MARK: one bit equal to the last TRN bit, p not toggled; tx_sgn <= that bit. -> GUARD, or HDR if guard length is 0.
  - GUARD: alternating bits starting at ~marker bit, TX_GUARD_LEN bits. -> HDR.
  - HDR: HDR_WIDTH bits, MSB first. -> PAY, or -> IDLE with done if payload length is 0.
  - PAY: TX_PAY_LEN bits. -> IDLE with done.
- Latency: the first TRN bit appears on BPSK at the enable cycle after start is sampled. BPSK/tx_vld are registered.
- Frame length: TRN + 1 + GUARD + HDR_WIDTH + PAY bits. tx_vld is high for exactly that many enable cycles; busy covers the same window.
- done: pulses on the enable cycle after the last bit, together with tx_vld=0. A new start is accepted in that same cycle (back-to-back frames with one idle bit).
- Payload handshake:
  - pay_rdy = clk_enable & state==PAY.
  - A bit is consumed when pay_rdy & pay_vld.
  - If pay_vld=0 while pay_rdy=1: emit 0, set underflow. The frame never stalls.
- Outside a frame: BPSK=0, tx_vld=0.
- Counters saturate on no condition and never wrap: each state counts to its latched length-1 and transitions. Length inputs are sampled only at start; changes mid-frame have no effect.

Decomposition:
- Package tx_frame_pkg holds:
  - state encoding constants: IDLE, TRN, MARK, GUARD, HDR, PAY;
  - default widths;
  - the minimum TRN length constant (2).
- One natural sub-module: tx_hdr_serializer. It does load/shift of MSB-first parallel-to-serial, with a last-bit flag. The rest is one FSM with a shared down-counter.

Test Plan:
- TRN=6, GUARD=4, hdr=8'hA5, PAY=3 with bits 1,0,1 always valid -> BPSK = 0101 01 1 0101 10100101 101 (22 bits); tx_vld high 22 cycles; tx_sgn=1; done one pulse; underflow=0.
- TRN=1, GUARD=0, PAY=0, hdr=8'h00 -> TRN clamped to 0,1; marker 1; 8 zeros; 11 bits total; done after bit 11.
- Payload with pay_vld low on the 2nd of 4 bits -> that bit emitted as 0; underflow=1 sticky until next start; frame length unchanged.
- clk_enable duty 1/4, TRN=4, GUARD=2, PAY=2 -> same bit sequence as full-rate, each bit held 4 clocks; pay_rdy only on enable cycles.
- rst pulsed during GUARD -> next clk all outputs 0, IDLE, no done. Then start -> a fresh frame from TRN bit 0.
- start held continuously -> frames back-to-back separated by exactly one tx_vld=0 enable cycle; start during busy ignored. Looped into the receiver boundary detector with window 4 and GUARD=4, the detector flags once per frame with sign 1.
